i2s_rx: RTL and testbench

I2S_RX -- requirements
Module: i2s_rx

---
 rtl/i2s_pkg.sv | 17 +
 rtl/i2s_sync.sv | 24 ++
 rtl/i2s_rx.sv | 123 ++++++++++++
 tb/tb_i2s_rx.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S receive path.
package i2s_pkg;

  // Capture FSM: wait for the first boundary, drop the slot-start bit,
  // shift the word, then idle until the next selected slot.
  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SKIP   = 2'd1,
    SHIFT  = 2'd2,
    IGNORE = 2'd3
  } state_t;

  // LRCLK level that identifies each channel.
  localparam int CH_LEFT  = 0;
  localparam int CH_RIGHT = 1;

endpackage

// File: rtl/i2s_sync.sv
// Two-flop synchronizer used to bring each I2S pin into the clk domain.
module i2s_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out
);

  logic [WIDTH-1:0] meta;

  // First stage may go metastable; the second stage gives it a full clk to settle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta     <= '0;
      sync_out <= '0;
    end else begin
      meta     <= async_in;
      sync_out <= meta;
    end
  end

endmodule

// File: rtl/i2s_rx.sv
// I2S receiver: captures one channel's DATA_WIDTH-bit word from each frame and
// presents it on data_out with a one-clk sample_valid pulse. Every bit of
// state advances only on a synchronized BCLK rising edge.
module i2s_rx
  import i2s_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int SLOT_WIDTH = 32,
  parameter int CHANNEL    = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i2s_bclk,
  input  logic                         i2s_lrclk,
  input  logic                         i2s_sdata,
  output logic                         sample_valid,
  output logic signed [DATA_WIDTH-1:0] data_out,
  output logic                         frame_err
);

  localparam int              CNT_W     = (SLOT_WIDTH > 1) ? $clog2(SLOT_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SLOT_WIDTH - 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);
  localparam int              SR_W      = DATA_WIDTH - 1;
  localparam logic            SEL_LEVEL = (CHANNEL == CH_RIGHT) ? 1'b1 : 1'b0;

  logic             bclk_s;
  logic             lrclk_s;
  logic             sdata_s;
  logic             bclk_d;
  logic             lrclk_prev;
  logic             lrclk_seen;
  logic             bit_event;
  logic             slot_start;
  logic             new_is_sel;
  logic [CNT_W-1:0] bit_cnt;
  logic [SR_W-1:0]  shift_reg;
  state_t           state;

  i2s_sync #(.WIDTH(1)) u_sync_bclk  (.clk(clk), .rst(rst), .async_in(i2s_bclk),  .sync_out(bclk_s));
  i2s_sync #(.WIDTH(1)) u_sync_lrclk (.clk(clk), .rst(rst), .async_in(i2s_lrclk), .sync_out(lrclk_s));
  i2s_sync #(.WIDTH(1)) u_sync_sdata (.clk(clk), .rst(rst), .async_in(i2s_sdata), .sync_out(sdata_s));

  // lrclk_seen stops the first bit event after reset from looking like a
  // boundary, so a slot already in progress at reset release is never captured.
  assign bit_event  = bclk_s & ~bclk_d;
  assign slot_start = bit_event & lrclk_seen & (lrclk_s != lrclk_prev);
  assign new_is_sel = (lrclk_s == SEL_LEVEL);

  // BCLK edge history and the LRCLK level seen at the previous bit event.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bclk_d     <= 1'b0;
      lrclk_prev <= 1'b0;
      lrclk_seen <= 1'b0;
    end else begin
      bclk_d <= bclk_s;
      if (bit_event) begin
        lrclk_prev <= lrclk_s;
        lrclk_seen <= 1'b1;
      end
    end
  end

  // Bit position within the current slot; 0 is the slot-start bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt <= '0;
    end else if (slot_start) begin
      bit_cnt <= '0;
    end else if (bit_event && bit_cnt != CNT_MAX) begin
      bit_cnt <= bit_cnt + 1'b1;
    end
  end

  // Capture FSM and datapath. The shift register holds the first DATA_WIDTH-1
  // bits; the final bit is merged directly into data_out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= HUNT;
      shift_reg    <= '0;
      data_out     <= '0;
      sample_valid <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      frame_err    <= 1'b0;
      if (bit_event) begin
        case (state)
          HUNT: begin
            if (slot_start && new_is_sel) state <= SKIP;
          end
          SKIP: begin
            if (slot_start) begin
              frame_err <= 1'b1;
              state     <= new_is_sel ? SKIP : IGNORE;
            end else begin
              shift_reg <= SR_W'(sdata_s);
              state     <= SHIFT;
            end
          end
          SHIFT: begin
            if (slot_start) begin
              frame_err <= 1'b1;
              state     <= new_is_sel ? SKIP : IGNORE;
            end else if (bit_cnt == LAST_BIT) begin
              data_out     <= {shift_reg, sdata_s};
              sample_valid <= 1'b1;
              state        <= IGNORE;
            end else begin
              shift_reg <= SR_W'({shift_reg, sdata_s});
            end
          end
          IGNORE: begin
            if (slot_start && new_is_sel) state <= SKIP;
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2s_rx.sv
// Bench for i2s_rx: a left-channel and a right-channel receiver share one I2S
// bus. Slots are described as (level, length, word); a slot-level model pushes
// the expected pulses into per-channel queues and a monitor pops and compares.
module tb_i2s_rx;
  import i2s_pkg::*;

  localparam int DW = 16;
  localparam int SW = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic i2s_bclk = 1'b0;
  logic i2s_lrclk = 1'b0;
  logic i2s_sdata = 1'b0;
  logic sv0, fe0, sv1, fe1;
  logic signed [DW-1:0] d0, d1;

  typedef struct packed {
    logic          is_err;
    logic [DW-1:0] data;
  } exp_t;

  exp_t     exp_left[$];
  exp_t     exp_right[$];
  int       stamps_left[$];
  int       checks = 0;
  int       passes = 0;
  int       cyc = 0;
  int       slots_since_reset = 0;
  logic [DW-1:0] last_data [2];
  bit       pending_short [2];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  i2s_rx #(.DATA_WIDTH(DW), .SLOT_WIDTH(SW), .CHANNEL(CH_LEFT)) dut_left (
    .clk(clk), .rst(rst), .i2s_bclk(i2s_bclk), .i2s_lrclk(i2s_lrclk),
    .i2s_sdata(i2s_sdata), .sample_valid(sv0), .data_out(d0), .frame_err(fe0)
  );

  i2s_rx #(.DATA_WIDTH(DW), .SLOT_WIDTH(SW), .CHANNEL(CH_RIGHT)) dut_right (
    .clk(clk), .rst(rst), .i2s_bclk(i2s_bclk), .i2s_lrclk(i2s_lrclk),
    .i2s_sdata(i2s_sdata), .sample_valid(sv1), .data_out(d1), .frame_err(fe1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  task automatic push_exp(input int ch, input exp_t e);
    if (ch == 0) exp_left.push_back(e);
    else         exp_right.push_back(e);
  endtask

  task automatic model_reset();
    slots_since_reset = 0;
    for (int ch = 0; ch < 2; ch++) begin
      pending_short[ch] = 1'b0;
      last_data[ch]     = '0;
    end
  endtask

  // One BCLK period: data and word select change on the falling edge.
  task automatic drive_bit(input logic lvl, input logic d);
    i2s_lrclk = lvl;
    i2s_sdata = d;
    i2s_bclk  = 1'b0;
    #50;
    i2s_bclk  = 1'b1;
    #50;
  endtask

  task automatic drive_raw(input logic lvl, input int len);
    for (int b = 0; b < len; b++) drive_bit(lvl, 1'($urandom_range(0, 1)));
  endtask

  // A slot: bit 0 is the previous word's tail, bits 1..DW carry the word MSB
  // first, the rest is random padding. A selected slot seen from its start
  // yields a sample if it is long enough, otherwise an error at the next slot.
  task automatic applyStimulus(input logic lvl, input int len, input logic [DW-1:0] word);
    bit   capture_ok [2];
    logic d;
    exp_t e;
    for (int ch = 0; ch < 2; ch++) begin
      if (pending_short[ch]) begin
        e.is_err = 1'b1;
        e.data   = last_data[ch];
        push_exp(ch, e);
        pending_short[ch] = 1'b0;
      end
      capture_ok[ch] = (slots_since_reset > 0) && (lvl == (ch == 1));
    end
    for (int b = 0; b < len; b++) begin
      if (b >= 1 && b <= DW) d = word[DW-b];
      else                   d = 1'($urandom_range(0, 1));
      if (b == DW) begin
        for (int ch = 0; ch < 2; ch++) begin
          if (capture_ok[ch]) begin
            e.is_err = 1'b0;
            e.data   = word;
            push_exp(ch, e);
            last_data[ch] = word;
          end
        end
      end
      drive_bit(lvl, d);
    end
    for (int ch = 0; ch < 2; ch++) pending_short[ch] = capture_ok[ch] && (len <= DW);
    slots_since_reset++;
  endtask

  task automatic checkOutput(input int ch, input logic sv, input logic fe, input logic [DW-1:0] dout);
    exp_t e;
    if (sv || fe) begin
      check($sformatf("ch%0d_valid_err_exclusive", ch), {31'b0, sv & fe}, 32'd0);
      if ((ch == 0 ? exp_left.size() : exp_right.size()) == 0) begin
        checks++;
        $display("[TB] FAIL ch%0d_unexpected_pulse: got valid=%0b err=%0b, expected no pulse", ch, sv, fe);
      end else begin
        if (ch == 0) e = exp_left.pop_front();
        else         e = exp_right.pop_front();
        check($sformatf("ch%0d_pulse_kind_is_err", ch), {31'b0, fe}, {31'b0, e.is_err});
        check($sformatf("ch%0d_data_out", ch), {16'b0, dout}, {16'b0, e.data});
      end
      if (ch == 0 && sv) stamps_left.push_back(cyc);
    end
  endtask

  // Monitor: pulses are registered on posedge, so look at them on negedge.
  always @(negedge clk) begin
    if (rst) begin
      checkOutput(0, sv0, fe0, d0);
      checkOutput(1, sv1, fe1, d1);
    end
  end

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected end of stimulus");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   n;
    int   len;
    logic lvl;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_data_left",   32'(d0),  32'd0);
    check("reset_data_right",  32'(d1),  32'd0);
    check("reset_valid_left",  {31'b0, sv0}, 32'd0);
    check("reset_err_left",    {31'b0, fe0}, 32'd0);
    check("reset_valid_right", {31'b0, sv1}, 32'd0);
    check("reset_err_right",   {31'b0, fe1}, 32'd0);
    rst = 1'b1;
    model_reset();

    // Warm-up slot, then basic capture of a known left word.
    applyStimulus(1'b1, SW, DW'($urandom));
    applyStimulus(1'b0, SW, 16'h1234);
    applyStimulus(1'b1, SW, DW'($urandom));

    // Full-scale negative then positive, one frame apart.
    n = stamps_left.size();
    applyStimulus(1'b0, SW, 16'h8000);
    applyStimulus(1'b1, SW, DW'($urandom));
    applyStimulus(1'b0, SW, 16'h7FFF);
    applyStimulus(1'b1, SW, DW'($urandom));
    repeat (5) @(negedge clk);
    checks++;
    if (stamps_left.size() >= n + 2 &&
        stamps_left[n+1] - stamps_left[n] >= 2*SW*10 - 1 &&
        stamps_left[n+1] - stamps_left[n] <= 2*SW*10 + 1)
      passes++;
    else
      $display("[TB] FAIL frame_spacing: got %0d pulses after mark, expected 2 pulses %0d clks apart",
               stamps_left.size() - n, 2*SW*10);

    // Distinct left/right words.
    applyStimulus(1'b0, SW, 16'hAAAA);
    applyStimulus(1'b1, SW, 16'h5555);

    // Short left slot, then normal frames.
    applyStimulus(1'b0, 10, DW'($urandom));
    applyStimulus(1'b1, SW, DW'($urandom));
    applyStimulus(1'b0, SW, DW'($urandom));
    applyStimulus(1'b1, SW, DW'($urandom));

    // Random words and occasional truncated slots, including the DW / DW+1 edges.
    lvl = 1'b0;
    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 5))
        0:       len = $urandom_range(1, SW);
        1:       len = DW;
        2:       len = DW + 1;
        default: len = SW;
      endcase
      applyStimulus(lvl, len, DW'($urandom));
      lvl = ~lvl;
    end
    applyStimulus(1'b0, SW, DW'($urandom));
    applyStimulus(1'b1, SW, DW'($urandom));

    // Reset in the middle of a left word.
    applyStimulus(1'b0, 10, DW'($urandom));
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midreset_data_left",   32'(d0),  32'd0);
    check("midreset_data_right",  32'(d1),  32'd0);
    check("midreset_valid_left",  {31'b0, sv0}, 32'd0);
    check("midreset_err_left",    {31'b0, fe0}, 32'd0);
    check("midreset_valid_right", {31'b0, sv1}, 32'd0);
    check("midreset_err_right",   {31'b0, fe1}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    model_reset();
    applyStimulus(1'b0, SW - 10, DW'($urandom));
    applyStimulus(1'b1, SW, DW'($urandom));
    applyStimulus(1'b0, SW, DW'($urandom));
    applyStimulus(1'b1, SW, DW'($urandom));

    // Reset released part-way through a slot.
    rst = 1'b0;
    drive_raw(1'b0, 12);
    rst = 1'b1;
    model_reset();
    applyStimulus(1'b0, SW - 12, DW'($urandom));
    applyStimulus(1'b1, SW, DW'($urandom));
    applyStimulus(1'b0, SW, DW'($urandom));
    applyStimulus(1'b1, SW, DW'($urandom));

    repeat (20) @(negedge clk);
    check("left_expected_left_over",  32'(exp_left.size()),  32'd0);
    check("right_expected_left_over", 32'(exp_right.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
